pwm_timebase: RTL and testbench

Parametrised PWM timebase for the fan motor controller. It generalises the fixed 0..999 wrap counter with:
- programmable period, shadow-loaded so period changes never glitch;
- programmable clock prescaler;
- sawtooth (up) and triangle (up-down) count modes;
- enable, synchronous restart, zero/top strobes for downstream compare and duty logic.

---
 rtl/pwm_timebase_pkg.sv | 15 +
 rtl/pwm_prescaler.sv | 38 +++
 rtl/pwm_timebase.sv | 129 ++++++++++++
 tb/tb_pwm_timebase.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_timebase_pkg.sv
// Shared constants for the fan-motor PWM timebase: count modes, directions
// and the default geometry of the counter.
package pwm_timebase_pkg;

  localparam int DEF_WIDTH      = 10;
  localparam int DEF_PRESCALE_W = 8;
  localparam int DEF_PERIOD     = 999;

  localparam logic MODE_UP     = 1'b0;
  localparam logic MODE_UPDOWN = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: o_tick pulses on the enabled clock where the count has
// reached the reload value, so a tick occurs every i_prescale+1 clocks.
module pwm_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] presc_cnt_r;
  logic                  reached_s;

  // Using >= lets a lowered reload value take effect on the very next clock.
  assign reached_s = (presc_cnt_r >= i_prescale);
  assign o_tick    = i_enable & ~i_clear & reached_s;

  // Prescale counter: clear wins, then freeze, then count/reload.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_cnt_r <= '0;
    end else if (i_clear) begin
      presc_cnt_r <= '0;
    end else if (!i_enable) begin
      presc_cnt_r <= presc_cnt_r;
    end else if (reached_s) begin
      presc_cnt_r <= '0;
    end else begin
      presc_cnt_r <= presc_cnt_r + PRESC_ONE;
    end
  end

endmodule

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled sawtooth or triangle counter with shadowed period
// and mode that only change at a zero boundary or on a synchronous clear.
module pwm_timebase
  import pwm_timebase_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int PRESCALE_W     = DEF_PRESCALE_W,
  parameter int DEFAULT_PERIOD = DEF_PERIOD
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_mode,
  input  logic [WIDTH-1:0]      i_period,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_sync_clear,
  output logic [WIDTH-1:0]      o_counter,
  output logic                  o_dir,
  output logic                  o_zero,
  output logic                  o_top,
  output logic [WIDTH-1:0]      o_period_active
);

  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_PER   = WIDTH'(DEFAULT_PERIOD);

  logic             tick_s;
  logic [WIDTH-1:0] cnt_r, cnt_nxt_s, cnt_inc_s, cnt_dec_s;
  logic [WIDTH-1:0] per_r, per_nxt_s;
  logic             mode_r, mode_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic             zero_r, zero_nxt_s;
  logic             top_r, top_nxt_s;
  logic             reload_s;

  pwm_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_clear    (i_sync_clear),
    .i_prescale (i_prescale),
    .o_tick     (tick_s)
  );

  assign cnt_inc_s = cnt_r + CNT_ONE;
  assign cnt_dec_s = cnt_r - CNT_ONE;

  // Next-state rules for counter, direction, strobes and shadow reload.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    dir_nxt_s  = dir_r;
    zero_nxt_s = 1'b0;
    top_nxt_s  = 1'b0;
    reload_s   = 1'b0;
    if (i_sync_clear) begin
      cnt_nxt_s = '0;
      dir_nxt_s = DIR_UP;
      reload_s  = 1'b1;
    end else if (tick_s) begin
      if (per_r == '0) begin
        cnt_nxt_s  = '0;
        dir_nxt_s  = DIR_UP;
        zero_nxt_s = 1'b1;
        top_nxt_s  = 1'b1;
        reload_s   = 1'b1;
      end else if (mode_r == MODE_UP) begin
        dir_nxt_s = DIR_UP;
        if (cnt_r >= per_r) begin
          cnt_nxt_s  = '0;
          zero_nxt_s = 1'b1;
          reload_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_inc_s;
          top_nxt_s = (cnt_inc_s == per_r);
        end
      end else if ((dir_r == DIR_DOWN) || (cnt_r >= per_r)) begin
        // Also covers a count left above the period by a mode switch.
        if (cnt_r <= CNT_ONE) begin
          cnt_nxt_s  = '0;
          dir_nxt_s  = DIR_UP;
          zero_nxt_s = 1'b1;
          reload_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_dec_s;
          dir_nxt_s = DIR_DOWN;
        end
      end else begin
        cnt_nxt_s = cnt_inc_s;
        top_nxt_s = (cnt_inc_s == per_r);
        dir_nxt_s = (cnt_inc_s == per_r) ? DIR_DOWN : DIR_UP;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
    if (reload_s) begin
      per_nxt_s  = i_period;
      mode_nxt_s = i_mode;
    end else begin
      per_nxt_s  = per_r;
      mode_nxt_s = mode_r;
    end
  end

  // State and strobe registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_r  <= '0;
      dir_r  <= DIR_UP;
      per_r  <= RST_PER;
      mode_r <= MODE_UP;
      zero_r <= 1'b0;
      top_r  <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      dir_r  <= dir_nxt_s;
      per_r  <= per_nxt_s;
      mode_r <= mode_nxt_s;
      zero_r <= zero_nxt_s;
      top_r  <= top_nxt_s;
    end
  end

  assign o_counter       = cnt_r;
  assign o_dir           = dir_r & mode_r;
  assign o_zero          = zero_r;
  assign o_top           = top_r;
  assign o_period_active = per_r;

endmodule

// File: tb/tb_pwm_timebase.sv
// Self-checking bench for pwm_timebase: phase-based reference model compared
// every cycle, directed scenarios with literal expectations, random stimulus.
module tb_pwm_timebase;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [9:0] period = 10'd999;
  logic [7:0] presc = 8'd0;
  logic       sclr = 1'b0;
  logic [9:0] o_counter;
  logic       o_dir, o_zero, o_top;
  logic [9:0] o_period_active;

  int n_checks = 0;
  int n_pass = 0;
  int cyc_no = 0;

  // model: position within the current cycle, plus shadows and prescale count
  int m_phase, m_per, m_presc;
  bit m_mode, m_zero, m_top;

  pwm_timebase dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_mode(mode),
    .i_period(period), .i_prescale(presc), .i_sync_clear(sclr),
    .o_counter(o_counter), .o_dir(o_dir), .o_zero(o_zero), .o_top(o_top),
    .o_period_active(o_period_active)
  );

  always #5 clk = ~clk;

  function automatic int exp_cnt();
    if (!m_mode || m_phase <= m_per) return m_phase;
    return 2 * m_per - m_phase;
  endfunction

  function automatic bit exp_dir();
    return m_mode && (m_per > 0) && (m_phase >= m_per);
  endfunction

  task automatic model_step();
    bit tick, reload;
    reload = 1'b0;
    if (rst) begin
      m_phase = 0; m_presc = 0; m_per = 999; m_mode = 1'b0; m_zero = 1'b0; m_top = 1'b0;
    end else if (sclr) begin
      m_phase = 0; m_presc = 0; m_per = int'(period); m_mode = mode; m_zero = 1'b0; m_top = 1'b0;
    end else if (!en) begin
      m_zero = 1'b0; m_top = 1'b0;
    end else begin
      tick = (m_presc >= int'(presc));
      m_presc = tick ? 0 : m_presc + 1;
      m_zero = 1'b0; m_top = 1'b0;
      if (tick) begin
        if (m_per == 0) begin
          m_zero = 1'b1; m_top = 1'b1; reload = 1'b1; m_phase = 0;
        end else begin
          m_phase = m_phase + 1;
          if (m_phase == m_per) m_top = 1'b1;
          if (m_phase == (m_mode ? 2 * m_per : m_per + 1)) begin
            m_phase = 0; m_zero = 1'b1; reload = 1'b1;
          end
        end
        if (reload) begin
          m_per = int'(period); m_mode = mode;
        end
      end
    end
  endtask

  // Advance one clock and compare every output with the model.
  task automatic cyc();
    model_step();
    @(negedge clk);
    cyc_no++;
    n_checks++;
    if (int'(o_counter) == exp_cnt() && o_dir == exp_dir() && o_zero == m_zero &&
        o_top == m_top && int'(o_period_active) == m_per) begin
      n_pass++;
    end else begin
      $display("FAIL model cyc=%0d cnt=%0d/%0d dir=%0b/%0b zero=%0b/%0b top=%0b/%0b per=%0d/%0d",
               cyc_no, o_counter, exp_cnt(), o_dir, exp_dir(), o_zero, m_zero,
               o_top, m_top, o_period_active, m_per);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_with(input logic m, input logic [9:0] p, input logic [7:0] ps);
    mode = m; period = p; presc = ps; sclr = 1'b1;
    cyc();
    sclr = 1'b0;
  endtask

  task automatic run_until_cnt(input int target, input int bound);
    int i;
    for (i = 0; i < bound && int'(o_counter) != target; i++) cyc();
    lit("reach_count", int'(o_counter), target);
  endtask

  int first_zero, first_top, top_cnt, z0, z1, t1, k, held_ok, both;
  int seq_e[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int dir_e[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
  int seq_a[8], dir_a[8];

  initial begin
    // reset state
    cyc(); cyc();
    lit("rst_counter", int'(o_counter), 0);
    lit("rst_period", int'(o_period_active), 999);
    lit("rst_strobes", int'({o_zero, o_top, o_dir}), 0);
    rst = 1'b0; en = 1'b1;

    // 1: default 0..999 sawtooth
    cyc_no = 0; first_zero = -1; first_top = -1; top_cnt = -1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (o_top && first_top < 0) begin first_top = cyc_no; top_cnt = int'(o_counter); end
      if (o_zero && first_zero < 0) first_zero = cyc_no;
    end
    lit("t1_first_zero", first_zero, 1000);
    lit("t1_first_top", first_top, 999);
    lit("t1_top_count", top_cnt, 999);

    // 2: period 4, prescale 3
    clear_with(1'b0, 10'd4, 8'd3);
    cyc_no = 0; z0 = -1; z1 = -1; t1 = -1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (o_zero && z0 < 0) z0 = cyc_no;
      else if (o_zero && z1 < 0) z1 = cyc_no;
      if (o_top && z0 >= 0 && t1 < 0) t1 = cyc_no;
    end
    lit("t2_zero_first", z0, 20);
    lit("t2_zero_interval", z1 - z0, 20);
    lit("t2_top_after_zero", t1 - z0, 16);

    // 3: triangle, period 3
    clear_with(1'b1, 10'd3, 8'd0);
    for (int i = 0; i < 8; i++) begin
      seq_a[i] = int'(o_counter); dir_a[i] = int'(o_dir);
      if (i == 3) lit("t3_top_at_3", int'(o_top), 1);
      if (i == 6) lit("t3_zero_at_0", int'(o_zero), 1);
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      lit("t3_seq", seq_a[i], seq_e[i]);
      lit("t3_dir", dir_a[i], dir_e[i]);
    end

    // 4: mid-cycle period write is shadowed
    clear_with(1'b0, 10'd999, 8'd0);
    run_until_cnt(500, 600);
    period = 10'd199;
    run_until_cnt(999, 600);
    lit("t4_shadow_held", int'(o_period_active), 999);
    cyc();
    lit("t4_wrap_zero", int'(o_zero), 1);
    lit("t4_new_period", int'(o_period_active), 199);
    k = 0;
    for (int i = 0; i < 300 && !o_top; i++) begin cyc(); k++; end
    lit("t4_top_after", k, 199);

    // 5: async reset between edges, then sync clear
    clear_with(1'b0, 10'd999, 8'd0);
    run_until_cnt(700, 800);
    #2 rst = 1'b1;
    #1;
    lit("t5_async_cnt", int'(o_counter), 0);
    lit("t5_async_per", int'(o_period_active), 999);
    cyc();
    rst = 1'b0;
    run_until_cnt(300, 400);
    clear_with(1'b0, 10'd50, 8'd0);
    lit("t5_clr_cnt", int'(o_counter), 0);
    lit("t5_clr_per", int'(o_period_active), 50);
    lit("t5_clr_nozero", int'(o_zero), 0);

    // 6: period 0, then enable freeze
    clear_with(1'b0, 10'd0, 8'd1);
    both = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (o_zero && o_top && o_counter == 10'd0) both++;
    end
    lit("t6_p0_strobes", both, 5);
    clear_with(1'b0, 10'd20, 8'd0);
    for (int i = 0; i < 7; i++) cyc();
    en = 1'b0; held_ok = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (o_counter == 10'd7 && !o_zero && !o_top) held_ok++;
    end
    lit("t6_frozen", held_ok, 5);
    en = 1'b1;
    cyc();
    lit("t6_resume", int'(o_counter), 8);

    // maximum period in both modes
    clear_with(1'b1, 10'd1023, 8'd0);
    for (int i = 0; i < 2100; i++) cyc();
    mode = 1'b0;
    for (int i = 0; i < 2200; i++) cyc();

    // randomized stimulus
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 4) presc = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) begin
        case ($urandom_range(0, 3))
          0: period = 10'd0;
          1: period = 10'($urandom_range(1, 3));
          2: period = 10'($urandom_range(4, 30));
          default: period = 10'($urandom_range(0, 12));
        endcase
      end
      if ($urandom_range(0, 99) < 5) mode = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 99) < 90);
      sclr = ($urandom_range(0, 199) < 2);
      cyc();
    end
    sclr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
